// File: rtl/mul_div_if.sv
// Handshake and result bus between the control unit / register file and mul_div_unit.
interface mul_div_if #(
    parameter int WIDTH      = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  start;
    logic [1:0]            op;
    logic [WIDTH-1:0]      operand_a;
    logic [WIDTH-1:0]      operand_b;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      result;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  reg_write;

    // Requester side: control unit issuing operations and consuming results.
    modport master (
        output start, op, operand_a, operand_b, dest_reg,
        input  busy, done, result, write_reg, reg_write
    );

    // Execute-unit side.
    modport slave (
        input  start, op, operand_a, operand_b, dest_reg,
        output busy, done, result, write_reg, reg_write
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multicycle unsigned multiply/divide unit: one shift-add or restoring-divide
// step per clock, fixed latency, single operation in flight.
module mul_div_unit #(
    parameter int WIDTH      = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic     Clk,
    input  logic     Rst,
    mul_div_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    logic [1:0]            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            op_q;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic [2*WIDTH-1:0]    prod_q;
    logic [WIDTH-1:0]      rem_q;
    logic [WIDTH-1:0]      quo_q;
    logic [WIDTH-1:0]      result_q;
    logic [REG_ADDR_W-1:0] wreg_q;

    // Select the architectural result from the finished accumulators. A zero
    // divisor needs no special case: every trial subtract succeeds, so the
    // quotient ends all ones and the remainder ends equal to the dividend.
    function automatic logic [WIDTH-1:0] pick_result(
        input logic [1:0]         op,
        input logic [2*WIDTH-1:0] prod,
        input logic [WIDTH-1:0]   quo,
        input logic [WIDTH-1:0]   rem
    );
        case (op)
            OP_MUL:   return prod[WIDTH-1:0];
            OP_MULHU: return prod[2*WIDTH-1:WIDTH];
            OP_DIVU:  return quo;
            default:  return rem;
        endcase
    endfunction

    // Shift-add step: conditionally add the multiplicand into the upper half,
    // then shift the whole product right with the carry coming back in on top.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_nxt;
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    assign prod_nxt = {mul_sum, prod_q[WIDTH-1:1]};

    // Restoring-divide step: the dividend shifts out of quo_q MSB-first while
    // quotient bits shift in at the bottom. Since rem_q < divisor, a
    // non-negative difference always fits back into WIDTH bits.
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;
    logic           sub_ok;
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, b_q};
    assign sub_ok    = ~rem_diff[WIDTH];

    // Control FSM plus datapath; the extra counter value after the last
    // iteration is the edge that publishes the result and enters DONE.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dest_q   <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            wreg_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        a_q     <= bus.operand_a;
                        b_q     <= bus.operand_b;
                        dest_q  <= bus.dest_reg;
                        cnt_q   <= '0;
                        prod_q  <= {{WIDTH{1'b0}}, bus.operand_b};
                        rem_q   <= '0;
                        quo_q   <= bus.operand_a;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (cnt_q == CNT_LAST) begin
                        result_q <= pick_result(op_q, prod_q, quo_q, rem_q);
                        wreg_q   <= dest_q;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        prod_q <= prod_nxt;
                        rem_q  <= sub_ok ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                        quo_q  <= {quo_q[WIDTH-2:0], sub_ok};
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.reg_write = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.write_reg = wreg_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: latency-counting reference model
// compared every cycle, directed corner cases with literal results, and
// randomized operations.
module tb_mul_div_unit;
    localparam int W  = 64;
    localparam int RW = 5;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    mul_div_if #(.WIDTH(W), .REG_ADDR_W(RW)) bus();

    mul_div_unit #(.WIDTH(W), .REG_ADDR_W(RW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Architectural result straight from the arithmetic definition.
    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (b == 0) ? {W{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Reference model: an accepted op produces its result W+1 edges later,
    // then one more edge frees the unit.
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    int            m_left = 0;
    logic [W-1:0]  m_result = '0;
    logic [RW-1:0] m_wreg = '0;
    logic [1:0]    p_op;
    logic [W-1:0]  p_a, p_b;
    logic [RW-1:0] p_dest;

    always @(posedge Clk) begin
        if (Rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_result = '0; m_wreg = '0;
        end else if (m_done) begin
            m_done = 1'b0; m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done   = 1'b1;
                m_result = ref_result(p_op, p_a, p_b);
                m_wreg   = p_dest;
            end
        end else if (bus.start) begin
            m_busy = 1'b1; m_left = W + 1;
            p_op = bus.op; p_a = bus.operand_a; p_b = bus.operand_b; p_dest = bus.dest_reg;
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge Clk) begin
        if (chk_en) begin
            check("busy", bus.busy, m_busy);
            check("done", bus.done, m_done);
            check("reg_write", bus.reg_write, m_done);
            check("result", bus.result, m_result);
            check("write_reg", bus.write_reg, m_wreg);
            if (bus.done === 1'b1) n_done++;
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [RW-1:0] d, input bit lit, input logic [W-1:0] exp_lit);
        int cnt;
        @(negedge Clk);
        bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.dest_reg = d; bus.start = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        bus.operand_a = {$urandom, $urandom};
        bus.operand_b = {$urandom, $urandom};
        bus.dest_reg  = RW'($urandom);
        bus.op        = 2'($urandom);
        cnt = 1;
        while (bus.done !== 1'b1 && cnt < 200) begin
            @(negedge Clk);
            cnt++;
        end
        if (bus.done !== 1'b1) begin
            check("done_timeout", 0, 1);
        end else if (lit) begin
            check("latency", cnt, W + 2);
            check("lit_result", bus.result, exp_lit);
            check("lit_write_reg", bus.write_reg, d);
            check("model_pin", m_result, exp_lit);
        end
        @(negedge Clk);
        if (lit) begin
            check("busy_after_done", bus.busy, 0);
            check("done_after_done", bus.done, 0);
        end
    endtask

    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

    initial begin
        int done_base;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        bus.start = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0; bus.dest_reg = '0;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        chk_en = 1'b1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        check("reset_write_reg", bus.write_reg, 0);
        Rst = 1'b0;

        run_op(2'b00, 64'd3, 64'd5, 5'd7, 1'b1, 64'd15);
        run_op(2'b01, ONES, ONES, 5'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(2'b00, ONES, ONES, 5'd2, 1'b1, 64'h1);
        run_op(2'b10, 64'd100, 64'd7, 5'd0, 1'b1, 64'd14);
        run_op(2'b11, 64'd100, 64'd7, 5'd31, 1'b1, 64'd2);
        run_op(2'b10, MSB, 64'd1, 5'd9, 1'b1, MSB);
        run_op(2'b10, 64'd42, 64'd0, 5'd10, 1'b1, ONES);
        run_op(2'b11, 64'd42, 64'd0, 5'd11, 1'b1, 64'd42);

        // Start requests while busy (mid-calc and during DONE) must be dropped.
        done_base = n_done;
        @(negedge Clk);
        bus.op = 2'b00; bus.operand_a = 64'd6; bus.operand_b = 64'd7; bus.dest_reg = 5'd3; bus.start = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        repeat (10) @(negedge Clk);
        bus.op = 2'b10; bus.operand_a = 64'd9; bus.operand_b = 64'd3; bus.dest_reg = 5'd4; bus.start = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        for (int i = 0; i < 200 && bus.done !== 1'b1; i++) @(negedge Clk);
        check("collide_result", bus.result, 64'd42);
        check("collide_write_reg", bus.write_reg, 3);
        bus.start = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        repeat (W + 10) @(negedge Clk);
        check("collide_done_count", n_done - done_base, 1);

        // Reset mid-calculation discards the operation.
        done_base = n_done;
        @(negedge Clk);
        bus.op = 2'b00; bus.operand_a = 64'h1234; bus.operand_b = 64'h99; bus.dest_reg = 5'd5; bus.start = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        repeat (30) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_result", bus.result, 0);
        check("rst_mid_done", bus.done, 0);
        repeat (W + 10) @(negedge Clk);
        check("rst_mid_no_done", n_done - done_base, 0);
        run_op(2'b00, 64'd2, 64'd2, 5'd6, 1'b1, 64'd4);

        // Randomized operations against the model.
        for (int k = 0; k < 24; k++) begin
            rop = 2'($urandom);
            ra  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1000)) : {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 255));
                default: rb = {$urandom, $urandom};
            endcase
            run_op(rop, ra, rb, RW'($urandom), 1'b0, '0);
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
